// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the registered immediate extender.
// Holds the format-select codes, the default XLEN and the entry type held
// in the OUT/SKID slots. Entry fields are sized for the widest legal
// configuration; instances use the low XLEN / TAG_W bits.
package imm_pkg;

    // Format select codes. 000..010 keep the legacy 2-bit meaning.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    localparam int DEFAULT_XLEN = 32;

    // Storage widths of an entry; XLEN <= XLEN_MAX and TAG_W <= TAG_W_MAX.
    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [XLEN_MAX-1:0]  immext;
        logic [TAG_W_MAX-1:0] tag;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_extend_pipe_format.sv
// Combinational immediate decoder for the RV32I/RV64I formats.
// Optional feature: IMM_EXTEND_ZCSR_EN enables the zero-extended CSR
// immediate (select 101); without it that select is reported illegal.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    // Every legal format fits in 32 bits with bit 31 as its sign, so the
    // XLEN result is just a sign extension of this 32-bit value.
    logic [31:0] imm32;

    // Select the format; unknown selects give zero and raise illegal.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
`ifdef IMM_EXTEND_ZCSR_EN
            IMM_Z:   imm32 = {27'b0, instr[19:15]};
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Z-format has bit 31 clear, so sign extension is also correct there.
    assign immext = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-slot OUT/SKID buffer.
// Decodes on the input side, holds results in OUT (drives the outputs)
// and SKID (catches one extra accept under back-pressure). in_ready comes
// straight from the SKID valid flop. Optional feature macro:
// IMM_EXTEND_ZCSR_EN (see imm_format).
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic            fmt_illegal;
    logic [XLEN-1:0] fmt_immext;
    imm_entry_t      new_entry;

    imm_entry_t out_q, skid_q;
    logic       out_valid_q, skid_valid_q;

    logic accept, fire, load_out, load_skid;

    imm_format #(.XLEN(XLEN)) u_format (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .immext  (fmt_immext),
        .illegal (fmt_illegal)
    );

    // Widen the decoded request into the storage entry format.
    always_comb begin
        new_entry         = '0;
        new_entry.immext  = XLEN_MAX'(fmt_immext);
        new_entry.tag     = TAG_W_MAX'(in_tag);
        new_entry.illegal = fmt_illegal;
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign fire     = out_valid_q & out_ready;

    // A new entry goes to OUT when OUT is free now or is drained this cycle
    // with nothing waiting in SKID; otherwise it parks in SKID.
    assign load_out  = accept & (~out_valid_q | (fire & ~skid_valid_q));
    assign load_skid = accept & ~load_out;

    // Slot state: reset and flush drop everything, then drain/refill in FIFO order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            // SKID valid implies in_ready low, so no accept competes here.
            if (fire && skid_valid_q) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (load_out) begin
                out_q       <= new_entry;
                out_valid_q <= 1'b1;
            end else if (fire) begin
                out_valid_q <= 1'b0;
            end
            if (load_skid) begin
                skid_q       <= new_entry;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_immext  = out_q.immext[XLEN-1:0];
    assign out_tag     = out_q.tag[TAG_W-1:0];
    assign out_illegal = out_q.illegal;

    // Storage bits above XLEN / TAG_W are held at zero and never driven out.
    logic unused_bits;
    assign unused_bits = ^{out_q.immext, out_q.tag};

endmodule
